// File: rtl/perm_pkg.sv
// Shared definitions for the lane permutation engine: grid geometry,
// FSM state type and the lane index maps.
package perm_pkg;

    localparam int GRID  = 5;
    localparam int LANES = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Destination index of lane i (i = 5a+b) under the forward map.
    function automatic int fwd_idx(input int i, input int ofs);
        int a;
        int b;
        a = i / GRID;
        b = i % GRID;
        return GRID * ((2 * b + 3 * a + ofs) % GRID) + a;
    endfunction

    // Destination index of lane i (i = 5r+c) under the inverse map.
    function automatic int inv_idx(input int i, input int ofs);
        int r;
        int c;
        r = i / GRID;
        c = i % GRID;
        return GRID * c + ((3 * r + c + 3 * (GRID - ofs)) % GRID);
    endfunction

endpackage

// File: rtl/perm_lane_map.sv
// One round of the lane permutation, purely combinational. Whole lanes are
// routed; bits inside a lane are never touched. Each output lane is written
// as a gather: the source of output j under a map is the index the opposite
// map sends j to, because the two maps are exact inverses of each other.
module perm_lane_map
    import perm_pkg::*;
#(
    parameter int W   = 8,
    parameter int OFS = 2
) (
    input  logic [LANES*W-1:0] state,
    input  logic               inverse,
    output logic [LANES*W-1:0] mapped
);

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            localparam int FWD_SRC = inv_idx(j, OFS);
            localparam int INV_SRC = fwd_idx(j, OFS);
            assign mapped[j*W +: W] = inverse ? state[INV_SRC*W +: W]
                                              : state[FWD_SRC*W +: W];
        end
    endgenerate

endmodule

// File: rtl/permutation_engine.sv
// Iterated lane permutation engine. A job (state, round count, direction) is
// accepted over a valid/ready input handshake, one map is applied per clock
// in RUN, and the result is held in DONE until the output handshake completes.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high; valid must not depend on ready, and the producer holds
// its data stable while valid is high and ready is low.
module permutation_engine
    import perm_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAX_ROUNDS = 24,
    parameter int OFS        = 2,
    localparam int RW        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LANES*W-1:0] in_data,
    input  logic [RW-1:0]      in_rounds,
    input  logic               in_inverse,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [LANES*W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    state_t             st;
    logic [RW-1:0]      count;
    logic               mode;
    logic [LANES*W-1:0] data_q;
    logic [LANES*W-1:0] mapped;
    logic [RW-1:0]      rounds_sat;
    logic               accept;

    perm_lane_map #(
        .W   (W),
        .OFS (OFS)
    ) u_map (
        .state   (data_q),
        .inverse (mode),
        .mapped  (mapped)
    );

    // Round counts beyond the supported maximum are clamped at accept.
    assign rounds_sat = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;

    // DONE can take a new job in the same edge the result is consumed.
    assign in_ready  = (st == IDLE) || ((st == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (st == DONE);
    assign busy      = (st == RUN);
    assign out_data  = data_q;
    assign dbg_state = st;

    // Job load, per-round update and result hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            count  <= '0;
            mode   <= 1'b0;
            data_q <= '0;
        end else begin
            case (st)
                IDLE, DONE: begin
                    if (accept) begin
                        data_q <= in_data;
                        count  <= rounds_sat;
                        mode   <= in_inverse;
                        st     <= (rounds_sat == '0) ? DONE : RUN;
                    end else if (st == DONE && out_ready) begin
                        st <= IDLE;
                    end
                end
                RUN: begin
                    data_q <= mapped;
                    count  <= count - RW'(1);
                    if (count == RW'(1)) begin
                        st <= DONE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_permutation_engine.sv
// Self-checking bench for permutation_engine with W=8, MAX_ROUNDS=24, OFS=2.
module tb_permutation_engine;

    localparam int W    = 8;
    localparam int MAXR = 24;
    localparam int OFS  = 2;
    localparam int RW   = $clog2(MAXR + 1);
    localparam int LW   = 25 * W;

    logic          clk;
    logic          rst_n;
    logic [LW-1:0] in_data;
    logic [RW-1:0] in_rounds;
    logic          in_inverse;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_vec;
    int n_err;

    permutation_engine #(
        .W          (W),
        .MAX_ROUNDS (MAXR),
        .OFS        (OFS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_rounds  (in_rounds),
        .in_inverse (in_inverse),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Lane (a,b) at 5a+b goes to 5*((2b+3a+OFS)%5)+a forward;
    // lane (r,c) at 5r+c goes to 5c+((3r+c+3*(5-OFS))%5) inverse.
    function automatic logic [LW-1:0] ref_perm(input logic [LW-1:0] d, input int rounds, input bit inv);
        logic [LW-1:0] cur;
        logic [LW-1:0] nxt;
        int n;
        int dst;
        cur = d;
        nxt = '0;
        n = (rounds > MAXR) ? MAXR : rounds;
        for (int k = 0; k < n; k++) begin
            for (int a = 0; a < 5; a++) begin
                for (int b = 0; b < 5; b++) begin
                    if (!inv) dst = 5 * ((2 * b + 3 * a + OFS) % 5) + a;
                    else      dst = 5 * b + ((3 * a + b + 3 * (5 - OFS)) % 5);
                    nxt[dst*W +: W] = cur[(5*a+b)*W +: W];
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    function automatic logic [LW-1:0] rand_state();
        logic [LW-1:0] v;
        for (int i = 0; i < 25; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1 with the DUT idle; returns the result, the number
    // of edges from accept to out_valid, and the busy cycles seen; drains.
    task automatic do_job(input logic [LW-1:0] d, input int rounds, input bit inv,
                          output logic [LW-1:0] res, output int lat, output int bc);
        in_data    = d;
        in_rounds  = RW'(rounds);
        in_inverse = inv;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset: out_valid=%b busy=%b in_ready=%b out_data=%h, required 0 0 1 0",
                     out_valid, busy, in_ready, out_data);
        end
    endtask

    task automatic test_directed();
        logic [LW-1:0] d, res, exp;
        int lat, bc;
        d = '0;
        d[7:0] = 8'hA5;
        exp = '0;
        exp[10*W +: W] = 8'hA5;
        do_job(d, 1, 1'b0, res, lat, bc);
        n_vec++;
        if (res !== exp || lat !== 1) begin
            n_err++;
            $display("FAIL directed_r1: got %h lat %0d, required %h lat 1", res, lat, exp);
        end
        exp = '0;
        exp[17*W +: W] = 8'hA5;
        do_job(d, 2, 1'b0, res, lat, bc);
        n_vec++;
        if (res !== exp || lat !== 2 || bc !== 2) begin
            n_err++;
            $display("FAIL directed_r2: got %h lat %0d busy %0d, required %h lat 2 busy 2", res, lat, bc, exp);
        end
    endtask

    task automatic test_random();
        logic [LW-1:0] d, res, exp;
        int lat, bc, r;
        bit inv;
        for (int t = 0; t < 10; t++) begin
            d   = rand_state();
            r   = $urandom_range(0, 27);
            inv = 1'($urandom_range(0, 1));
            exp = ref_perm(d, r, inv);
            do_job(d, r, inv, res, lat, bc);
            n_vec++;
            if (res !== exp || lat !== ((r > MAXR) ? MAXR : r)) begin
                n_err++;
                $display("FAIL random[%0d] r=%0d inv=%0d: got %h lat %0d, required %h", t, r, inv, res, lat, exp);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [LW-1:0] d, r1, r2;
        int lat, bc;
        d = rand_state();
        do_job(d, 5, 1'b0, r1, lat, bc);
        n_vec++;
        if (r1 !== ref_perm(d, 5, 1'b0)) begin
            n_err++;
            $display("FAIL roundtrip_fwd: got %h, required %h", r1, ref_perm(d, 5, 1'b0));
        end
        do_job(r1, 5, 1'b1, r2, lat, bc);
        n_vec++;
        if (r2 !== d) begin
            n_err++;
            $display("FAIL roundtrip_inv: got %h, required %h", r2, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] d, d2, exp2;
        int lat;
        bit inv2;
        d = rand_state();
        in_data = d; in_rounds = '0; in_inverse = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand_state();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            n_err++;
            $display("FAIL zero_rounds: out_valid=%b data=%h, required 1 %h", out_valid, out_data, d);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== d) begin
                n_err++;
                $display("FAIL hold[%0d]: out_valid=%b data=%h, required 1 %h", k, out_valid, out_data, d);
            end
        end
        d2   = rand_state();
        inv2 = 1'($urandom_range(0, 1));
        exp2 = ref_perm(d2, 3, inv2);
        in_data = d2; in_rounds = RW'(3); in_inverse = inv2; in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_bubble: busy=%b out_valid=%b, required 1 0", busy, out_valid);
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (out_data !== exp2 || lat !== 3) begin
            n_err++;
            $display("FAIL b2b_result: got %h lat %0d, required %h lat 3", out_data, lat, exp2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [LW-1:0] d, res, exp;
        int lat, bc;
        d = '0;
        d[7:0] = 8'hA5;
        in_data = d; in_rounds = RW'(10); in_inverse = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_reset: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL after_reset: in_ready=%b out_valid=%b data=%h, required 1 0 0", in_ready, out_valid, out_data);
        end
        exp = '0;
        exp[10*W +: W] = 8'hA5;
        do_job(d, 1, 1'b0, res, lat, bc);
        n_vec++;
        if (res !== exp || lat !== 1) begin
            n_err++;
            $display("FAIL post_reset_job: got %h lat %0d, required %h lat 1", res, lat, exp);
        end
    endtask

    task automatic test_saturate();
        logic [LW-1:0] d, exp;
        int lat, bc;
        d   = rand_state();
        exp = ref_perm(d, MAXR, 1'b0);
        in_data = d; in_rounds = RW'(31); in_inverse = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bc++;
            in_data    = rand_state();
            in_rounds  = RW'($urandom_range(0, 31));
            in_inverse = 1'($urandom_range(0, 1));
            in_valid   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_data !== exp || bc !== MAXR || lat !== MAXR) begin
            n_err++;
            $display("FAIL saturate: got %h busy %0d lat %0d, required %h busy %0d", out_data, bc, lat, exp, MAXR);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL drain_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_rounds  = '0;
        in_inverse = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_directed();
        test_random();
        test_roundtrip();
        test_back_to_back();
        test_reset_midrun();
        test_saturate();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/permutation_engine.md
PERMUTATION_ENGINE -- requirements
Module: permutation_engine

Interface
REQ-001 The module SHALL have parameter W, default 8: lane width in bits.
REQ-002 The module SHALL have parameter MAX_ROUNDS, default 24: largest accepted round count.
REQ-003 The module SHALL have parameter OFS, default 2: row offset constant of the lane map, in range 0..4.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-005 Port in_data SHALL be an input of 25*W bits: the state, with lane i at bits [i*W +: W].
REQ-006 Port in_rounds SHALL be an input of RW = $clog2(MAX_ROUNDS+1) bits: the number of rounds to apply.
REQ-007 Port in_inverse SHALL be a 1-bit input: 0 selects the forward map, 1 selects the inverse map.
REQ-008 Port in_valid SHALL be a 1-bit input and in_ready a 1-bit output, forming the input handshake.
REQ-009 Port out_data SHALL be a 25*W-bit output carrying the permuted state.
REQ-010 Port out_valid SHALL be a 1-bit output and out_ready a 1-bit input, forming the output handshake.
REQ-011 Port busy SHALL be a 1-bit output, high while in the RUN state.

Function
REQ-012 Lane index i = 5a+b (a,b in 0..4); forward map SHALL move lane i to index 5*((2b+3a+OFS) mod 5)+a.
REQ-013 Inverse map SHALL move lane at index 5r+c to index 5c+((3r+c+3*(5-OFS)) mod 5), the exact inverse of REQ-012.
REQ-014 Whole W-bit lanes SHALL move; no bit within a lane is altered.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 in_ready SHALL be (IDLE) OR (DONE AND out_ready).
REQ-017 Accept SHALL occur on an edge with in_valid AND in_ready: state reg <= in_data, count <= in_rounds, mode <= in_inverse.
REQ-018 On accept with in_rounds = 0, next state SHALL be DONE with data unchanged.
REQ-019 On accept with in_rounds > 0, next state SHALL be RUN.
REQ-020 Each RUN edge SHALL apply one map per the latched mode and decrement count; on the edge where count = 1, next state SHALL be DONE.
REQ-021 Latency: if accept is at edge k, out_valid SHALL be high after edge k+R (R = rounds).
REQ-022 in_rounds > MAX_ROUNDS SHALL be saturated to MAX_ROUNDS at accept.
REQ-023 out_valid SHALL be high exactly in DONE; out_data SHALL equal the state register and stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1 and no accept SHALL go to IDLE.
REQ-025 DONE with out_ready=1 and a simultaneous accept SHALL load the new job in the same edge, with no idle bubble.
REQ-026 in_valid, in_data, in_rounds and in_inverse SHALL be ignored in RUN; a mid-run change SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, count=0, mode=0, state register=0, out_valid=0, busy=0 and in_ready=1 after release, regardless of the current state including mid-RUN.
REQ-028 A job interrupted by reset SHALL be discarded; no partial result is ever presented.

Structure
REQ-029 Package perm_pkg SHALL hold: GRID=5, LANES=25, the state enum type (IDLE/RUN/DONE), and functions fwd_idx(i) and inv_idx(i) parameterised by OFS.
REQ-030 Combinational sub-module perm_lane_map (parameters W and OFS; inputs state and inverse; output mapped state) SHALL implement REQ-012 to REQ-014 and be instantiated once.
REQ-031 All sequential logic SHALL reside in permutation_engine, with one always block sensitive to posedge clk or negedge rst_n.

Verification
REQ-032 Load lane 0 = 0xA5, others 0, R=1, forward -> out lane 10 = 0xA5, all others 0, out_valid 1 edge after accept.
REQ-033 Same input, R=2, forward -> lane 17 = 0xA5; out_valid 2 edges after accept with busy high for those 2 cycles.
REQ-034 Random state, R=5 forward, then output fed back with R=5 inverse -> original state restored bit-exact.
REQ-035 R=0 -> out_data = in_data after 1 edge; out_ready held 0 for 3 cycles -> out_data/out_valid stable; then out_ready=1 with in_valid=1 -> back-to-back accept, no IDLE cycle.
REQ-036 rst_n pulsed low mid-RUN (R=10, after 4 edges) -> out_valid=0, busy=0 immediately; next job R=1 lane 0 -> lane 10 correct.
REQ-037 in_rounds=31 with MAX_ROUNDS=24 -> exactly 24 RUN cycles; in_data changed during RUN -> result unaffected.
